// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core's data memory: access-size encodings
// and the wait-state controller's state enum.
package mips_pkg;

  typedef enum logic [2:0] {
    DM_W  = 3'd0,
    DM_H  = 3'd1,
    DM_HU = 3'd2,
    DM_B  = 3'd3,
    DM_BU = 3'd4
  } dm_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_lane.sv
// Byte-lane logic for the data memory: byte enables, store-lane merge into
// the addressed word, load extraction with sign/zero extension, and the
// alignment / range / opcode error check. Purely combinational.
module dm_lane
  import mips_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  output logic [31:0] merged,
  output logic [31:0] load_val,
  output logic        err
);

  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [15:0] half;
  logic [7:0]  byt;
  logic        bad_op;
  logic        bad_align;
  logic        out_of_range;

  // Decode the access size into enables, replicated store lanes and the load value
  always_comb begin
    be        = 4'b0000;
    wlanes    = wdata;
    load_val  = 32'd0;
    bad_op    = 1'b0;
    bad_align = 1'b0;
    half      = addr[1] ? old_word[31:16] : old_word[15:0];
    byt       = old_word[{addr[1:0], 3'b000} +: 8];
    case (op)
      DM_W: begin
        be        = 4'b1111;
        load_val  = old_word;
        bad_align = (addr[1:0] != 2'b00);
      end
      DM_H, DM_HU: begin
        be        = 4'b0011 << {addr[1], 1'b0};
        wlanes    = {2{wdata[15:0]}};
        load_val  = (op == DM_H) ? {{16{half[15]}}, half} : {16'h0000, half};
        bad_align = addr[0];
      end
      DM_B, DM_BU: begin
        be       = 4'b0001 << addr[1:0];
        wlanes   = {4{wdata[7:0]}};
        load_val = (op == DM_B) ? {{24{byt[7]}}, byt} : {24'h000000, byt};
      end
      default: bad_op = 1'b1;
    endcase
  end

  // Overlay the enabled store lanes onto the current word contents
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wlanes[8*i +: 8];
    end
  end

  // Anything at or above DEPTH*4 bytes falls outside the array
  assign out_of_range = ((addr >> (AW + 2)) != 32'd0);
  assign err          = bad_op | bad_align | out_of_range;

endmodule

// File: rtl/dm_ctrl.sv
// Data memory for the MEM stage. Sub-word stores via byte enables, extended
// sub-word loads, error detection, and optional wait states behind a
// req/busy/done handshake. With LATENCY = 0 it behaves as a single-cycle
// memory with combinational reads.
module dm_ctrl
  import mips_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0,
  parameter int DISPLAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        addr_err
);

  localparam int  AW    = $clog2(DEPTH);
  localparam int  CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit  LAT0  = (LATENCY == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  logic [31:0]      mem [DEPTH];
  dm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             we_l;
  logic [2:0]       op_l;
  logic [31:0]      addr_l, wdata_l, pc_l;
  logic [31:0]      rdata_q;

  logic             in_wait;
  logic             cur_we;
  logic [2:0]       cur_op;
  logic [31:0]      cur_addr, cur_wdata, cur_pc;
  logic [AW-1:0]    idx;
  logic [31:0]      old_word, merged, load_val;
  logic             lane_err;
  logic             accept, err_hit, finish, commit;

  // While waiting, the access is driven from the latched request, not the ports
  assign in_wait   = !LAT0 && (state_q == ST_WAIT);
  assign cur_we    = in_wait ? we_l    : we;
  assign cur_op    = in_wait ? op_l    : op;
  assign cur_addr  = in_wait ? addr_l  : addr;
  assign cur_wdata = in_wait ? wdata_l : wdata;
  assign cur_pc    = in_wait ? pc_l    : pc;
  assign idx       = cur_addr[AW+1:2];
  assign old_word  = mem[idx];

  dm_lane #(.AW(AW)) u_lane (
    .op       (cur_op),
    .addr     (cur_addr),
    .wdata    (cur_wdata),
    .old_word (old_word),
    .merged   (merged),
    .load_val (load_val),
    .err      (lane_err)
  );

  assign accept  = !reset && req && (state_q == ST_IDLE);
  assign err_hit = accept && lane_err;
  assign finish  = LAT0 ? (accept && !lane_err)
                        : (!reset && in_wait && (cnt_q == '0));
  assign commit  = finish && cur_we;

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && accept && !lane_err) cnt_q <= CNT_INIT;
      else if (in_wait)                                cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Next state: a clean request starts the wait, the last wait cycle returns
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!LAT0 && req && !lane_err) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0)               state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; the done-cycle load value is forwarded so it is usable immediately
  always_comb begin
    busy     = !reset && in_wait;
    done     = err_hit || finish;
    addr_err = err_hit;
    if (reset || err_hit)        rdata = 32'd0;
    else if (finish && !cur_we)  rdata = load_val;
    else                         rdata = rdata_q;
  end

  // Capture the request so the CPU's bus may change once busy is seen
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req) begin
      we_l    <= we;
      op_l    <= op;
      addr_l  <= addr;
      wdata_l <= wdata;
      pc_l    <= pc;
    end
  end

  // Completed loads are held until the next one finishes
  always_ff @(posedge clk) begin
    if (reset)                  rdata_q <= 32'd0;
    else if (finish && !cur_we) rdata_q <= load_val;
  end

  // Memory array: cleared on reset, written on a committed store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (commit) begin
      mem[idx] <= merged;
      if (DISPLAY != 0)
        $display("@%h: *%h <= %h", cur_pc, {cur_addr[31:2], 2'b00}, merged);
    end
  end

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: one single-cycle instance and one with three
// wait states, both driven from hand-computed vectors.
module tb_dm_ctrl;

  logic clk = 1'b0;
  logic reset;

  logic        a_req, a_we;
  logic [2:0]  a_op;
  logic [31:0] a_addr, a_wdata, a_pc;
  logic [31:0] a_rdata;
  logic        a_busy, a_done, a_err;

  logic        b_req, b_we;
  logic [2:0]  b_op;
  logic [31:0] b_addr, b_wdata, b_pc;
  logic [31:0] b_rdata;
  logic        b_busy, b_done, b_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_ctrl #(.DEPTH(1024), .LATENCY(0), .DISPLAY(1)) u_l0 (
    .clk(clk), .reset(reset), .req(a_req), .we(a_we), .op(a_op), .addr(a_addr),
    .wdata(a_wdata), .pc(a_pc), .rdata(a_rdata), .busy(a_busy), .done(a_done),
    .addr_err(a_err)
  );

  dm_ctrl #(.DEPTH(1024), .LATENCY(3), .DISPLAY(0)) u_l3 (
    .clk(clk), .reset(reset), .req(b_req), .we(b_we), .op(b_op), .addr(b_addr),
    .wdata(b_wdata), .pc(b_pc), .rdata(b_rdata), .busy(b_busy), .done(b_done),
    .addr_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle access; entered just after a posedge, leaves just after the next
  task automatic l0_acc(input string tag, input logic w, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    a_req = 1'b1; a_we = w; a_op = o; a_addr = a; a_wdata = d; a_pc = 32'h0040_0000 + a;
    @(negedge clk);
    check({tag, ".done"}, 32'(a_done), 32'd1);
    check({tag, ".busy"}, 32'(a_busy), 32'd0);
    check({tag, ".err"},  32'(a_err),  32'(exp_err));
    if (!w || exp_err) check({tag, ".rdata"}, a_rdata, exp_rd);
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  // Wait-state access; expects done three cycles after the request cycle
  task automatic l3_acc(input string tag, input logic w, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    int first_done;
    int busy_bad;
    first_done = -1;
    busy_bad   = 0;
    b_req = 1'b1; b_we = w; b_op = o; b_addr = a; b_wdata = d; b_pc = 32'h0040_1000 + a;
    @(negedge clk);
    check({tag, ".busy0"}, 32'(b_busy), 32'd0);
    check({tag, ".done0"}, 32'(b_done), 32'd0);
    for (int i = 1; i <= 8 && first_done < 0; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (b_busy !== 1'b1) busy_bad++;
      if (b_done === 1'b1) begin
        first_done = i;
        if (!w) check({tag, ".rdata_done"}, b_rdata, exp_rd);
      end
    end
    check({tag, ".latency"}, 32'(first_done), 32'd3);
    check({tag, ".busy_run"}, 32'(busy_bad), 32'd0);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    check({tag, ".busy_after"}, 32'(b_busy), 32'd0);
    check({tag, ".done_after"}, 32'(b_done), 32'd0);
    if (!w) check({tag, ".rdata_hold"}, b_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    a_req = 0; a_we = 0; a_op = 0; a_addr = 0; a_wdata = 0; a_pc = 0;
    b_req = 0; b_we = 0; b_op = 0; b_addr = 0; b_wdata = 0; b_pc = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.rdata", a_rdata, 32'd0);
    check("rst.done",  32'(a_done), 32'd0);
    check("rst.busy",  32'(b_busy), 32'd0);
    check("rst.err",   32'(a_err),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single-cycle: word, byte and half stores and loads
    l0_acc("lw_rst",  1'b0, 3'd0, 32'h10, 32'h0,        32'h0000_0000, 1'b0);
    l0_acc("sw10",    1'b1, 3'd0, 32'h10, 32'h12345678, 32'h0,         1'b0);
    l0_acc("lw10",    1'b0, 3'd0, 32'h10, 32'h0,        32'h12345678,  1'b0);
    l0_acc("sb11",    1'b1, 3'd3, 32'h11, 32'h000000AB, 32'h0,         1'b0);
    l0_acc("lw10b",   1'b0, 3'd0, 32'h10, 32'h0,        32'h1234AB78,  1'b0);
    l0_acc("lb11",    1'b0, 3'd3, 32'h11, 32'h0,        32'hFFFFFFAB,  1'b0);
    l0_acc("lbu11",   1'b0, 3'd4, 32'h11, 32'h0,        32'h000000AB,  1'b0);
    l0_acc("lh12",    1'b0, 3'd1, 32'h12, 32'h0,        32'h00001234,  1'b0);
    l0_acc("sh16",    1'b1, 3'd1, 32'h16, 32'h00008001, 32'h0,         1'b0);
    l0_acc("lh16",    1'b0, 3'd1, 32'h16, 32'h0,        32'hFFFF8001,  1'b0);
    l0_acc("lhu16",   1'b0, 3'd2, 32'h16, 32'h0,        32'h00008001,  1'b0);
    l0_acc("lw14",    1'b0, 3'd0, 32'h14, 32'h0,        32'h80010000,  1'b0);

    // Single-cycle: error cases must not write and must pulse addr_err once
    l0_acc("sw20",    1'b1, 3'd0, 32'h20, 32'hCAFEF00D, 32'h0,         1'b0);
    l0_acc("e_lw13",  1'b0, 3'd0, 32'h13, 32'h0,        32'h0,         1'b1);
    l0_acc("e_sh21",  1'b1, 3'd1, 32'h21, 32'h0000FFFF, 32'h0,         1'b1);
    l0_acc("e_swtop", 1'b1, 3'd0, 32'h1000, 32'hFFFFFFFF, 32'h0,       1'b1);
    l0_acc("e_op5",   1'b0, 3'd5, 32'h20, 32'h0,        32'h0,         1'b1);
    @(negedge clk);
    check("e_pulse.err",  32'(a_err),  32'd0);
    check("e_pulse.done", 32'(a_done), 32'd0);
    @(posedge clk); #1;
    l0_acc("lw20",    1'b0, 3'd0, 32'h20, 32'h0,        32'hCAFEF00D,  1'b0);
    l0_acc("lw00",    1'b0, 3'd0, 32'h00, 32'h0,        32'h00000000,  1'b0);

    // Three wait states: store, load back, sub-word load, immediate error
    l3_acc("b_sw40",  1'b1, 3'd0, 32'h40, 32'h5A5A1234, 32'h0);
    l3_acc("b_lw40",  1'b0, 3'd0, 32'h40, 32'h0,        32'h5A5A1234);
    l3_acc("b_lb41",  1'b0, 3'd3, 32'h41, 32'h0,        32'h00000012);
    b_req = 1'b1; b_we = 1'b0; b_op = 3'd0; b_addr = 32'h42;
    @(negedge clk);
    check("b_err.err",  32'(b_err),  32'd1);
    check("b_err.done", 32'(b_done), 32'd1);
    check("b_err.busy", 32'(b_busy), 32'd0);
    check("b_err.rdata", b_rdata, 32'd0);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    check("b_err.busy_next", 32'(b_busy), 32'd0);
    @(posedge clk); #1;

    // Reset two cycles into a store aborts it
    b_req = 1'b1; b_we = 1'b1; b_op = 3'd0; b_addr = 32'h44; b_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    b_req = 1'b0;
    @(negedge clk);
    check("b_rst.busy", 32'(b_busy), 32'd0);
    check("b_rst.done", 32'(b_done), 32'd0);
    @(posedge clk); #1;
    l3_acc("b_lw44",  1'b0, 3'd0, 32'h44, 32'h0, 32'h00000000);
    l3_acc("b_lw40r", 1'b0, 3'd0, 32'h40, 32'h0, 32'h00000000);
    l0_acc("lw10r",   1'b0, 3'd0, 32'h10, 32'h0, 32'h00000000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Parametrised data memory for the pipelined MIPS core's MEM stage; successor to the fixed 1024-word, word-only DM.
- Adds byte and halfword stores via byte enables, sign- or zero-extended sub-word loads, alignment and range error detection, and a configurable wait-state latency with a req/busy/done handshake.
- The pipeline stalls on busy.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two.
- LATENCY, 0: wait cycles per access; 0 = single-cycle behaviour.
- DISPLAY, 1: 1 = emit $display on every committed store.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  access request; held stable by the CPU while busy
- we  in  1  1 = store, 0 = load
- op  in  3  0 = word, 1 = half signed, 2 = half unsigned, 3 = byte signed, 4 = byte unsigned; store ignores signedness
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- pc  in  32  PC of the access instruction, used for display
- rdata  out  32  extended load result
- busy  out  1  access in progress; stall
- done  out  1  access completed this cycle
- addr_err  out  1  misaligned or out-of-range access; one-cycle pulse

Behaviour:
- Reset clears every word to 0, the FSM to IDLE, and rdata/busy/done/addr_err to 0. Reset during WAIT aborts the access with no write.
- Word index = addr[log2(DEPTH)+1:2].
- Byte enables:
  - word: 4'b1111
  - half: 4'b0011 << addr[1]*2
  - byte: 4'b0001 << addr[1:0]
- Store data lanes: wdata is replicated into the lanes, then written to the enabled lanes only.
- Load extraction: select lane by addr[1:0]; sign-extend for op 1/3, zero-extend for op 2/4.
- Error conditions:
  - half access with addr[0] = 1
  - word access with addr[1:0] != 0
  - addr >= DEPTH*4
  - op > 4
- On error: no write, addr_err = 1, rdata = 0, done = 1, busy = 0. Handled in the same cycle as the request regardless of LATENCY.
- LATENCY = 0:
  - Loads are combinational: rdata valid in the same cycle as req.
  - Stores commit at the posedge where req & we.
  - done = req; busy is always 0.
- LATENCY > 0, FSM IDLE -> WAIT -> IDLE:
  - IDLE: on req with no error, latch we/op/addr/wdata/pc; cnt <= LATENCY-1; go to WAIT; busy = 1 from the next cycle.
  - WAIT: cnt decrements each cycle. At cnt == 0, commit the store or register the load result into rdata. Pulse done for one cycle, drop busy, return to IDLE.
  - Total latency: done asserts LATENCY cycles after the req cycle.
  - rdata holds until the next completed load.
  - req in WAIT is ignored. A new req is accepted in the cycle after done.
- Display, when DISPLAY = 1, on each committed store: "@%h: *%h <= %h" printing pc, the word-aligned address, and the full merged 32-bit word.

Decomposition:
- Shared package (mips_pkg):
  - op encodings: DM_W, DM_H, DM_HU, DM_B, DM_BU
  - FSM state enum
- One natural sub-module, dm_lane: combinational byte-enable generation, store-lane replication, load extraction and extension, and error check.

Test Plan:
- LATENCY = 0: SW 0x12345678 @0x10, then LW @0x10 -> rdata = 0x12345678, done = 1, busy = 0; display "@<pc>: *00000010 <= 12345678".
- SB 0xAB @0x11 onto that word -> word = 0x1234AB78. Then:
  - LB @0x11 -> 0xFFFFFFAB
  - LBU @0x11 -> 0x000000AB
  - LH @0x12 -> 0x00001234
- SH 0x8001 @0x16, then:
  - LH @0x16 -> 0xFFFF8001
  - LHU -> 0x00008001
  - LW @0x14 -> 0x80010000
- Errors with no write: LW @0x13, SH @0x21, SW @DEPTH*4 -> addr_err = 1 for one cycle, rdata = 0. A following LW @0x20 returns the unchanged value.
- LATENCY = 3: req SW @0x40 at cycle t -> busy = 1 at t+1..t+3; done = 1 at t+3; memory updated at the t+3 edge. A req held during busy does not restart the access.
- LATENCY = 3: reset asserted at t+2 of a store -> no write; subsequent LW @0x40 returns 0. All memory reads 0 after reset.
